bus_fabric_n: RTL and testbench
===============================

Name: bus_fabric_n

Overview:
- Parametrised N-slave interconnect between the FemtoRV32 memory port and memory-mapped peripherals (memory, GPIO, UART, ...).
- Generalises the fixed 3-way address-decode/read-mux: per-slave base/mask decode, registered request issue, and slave ready/valid handshakes with master busy back-pressure.
- Adds a per-transaction timeout and a sticky bus-error capture for unmapped or hung accesses.

Parameters:
- N_SLAVES, 3, number of slave ports (1..16).
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- SLAVE_BASE, {32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed N_SLAVES*ADDR_W base addresses; slave 0 is in the LSBs.
- SLAVE_MASK, {3{32'hF000_0000}}, packed decode masks, one per slave.
- TIMEOUT, 255, cycles to wait for a slave response before error completion (1..2^TO_W-1).
- TO_W, 8, timeout counter width.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mem_addr  in  ADDR_W  master address.
- mem_wdata  in  DATA_W  master write data.
- mem_wmask  in  DATA_W/8  byte strobes; non-zero = write request.
- mem_rstrb  in  1  read request pulse.
- mem_rdata  out  DATA_W  registered read data.
- mem_rbusy  out  1  read in progress.
- mem_wbusy  out  1  write in progress.
- s_addr  out  ADDR_W  latched address & ~mask of selected slave (offset).
- s_wdata  out  DATA_W  latched write data.
- s_wstrb  out  DATA_W/8  latched strobes.
- s_ren  out  N_SLAVES  one-hot read pulse.
- s_wen  out  N_SLAVES  one-hot write pulse.
- s_rvalid  in  N_SLAVES  per-slave read-data valid.
- s_rdata  in  N_SLAVES*DATA_W  packed per-slave read data.
- s_wready  in  N_SLAVES  per-slave write accepted.
- err_clear  in  1  clears the error capture.
- err_valid  out  1  sticky bus-error flag.
- err_addr  out  ADDR_W  address of the first erroring access.
- err_is_write  out  1  the erroring access was a write.

Behaviour:
- Decode: slave i hits when (addr & MASK_i) == BASE_i. On multiple hits the lowest index wins. No hit = unmapped.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ERR.
- IDLE, write: |mem_wmask -> latch addr/wdata/wstrb and slave index, go to WR_REQ. If unmapped, go to ERR.
- IDLE, read: mem_rstrb -> latch address, go to RD_REQ, or ERR if unmapped.
- IDLE, simultaneous write and read: write wins; the read is dropped.
- Requests arriving outside IDLE are ignored.
- RD_REQ: s_ren[idx]=1 for this cycle only. Go to RD_WAIT, unless s_rvalid[idx] is already high, in which case complete.
- RD_WAIT: wait for s_rvalid[idx].
- Read complete: mem_rdata <= s_rdata slice idx; next state IDLE.
  - Minimum read latency: rstrb at cycle 0, ren at cycle 1, rdata valid with rbusy low at cycle 2.
- WR_REQ/WR_WAIT: analogous to reads, using s_wen[idx] and s_wready[idx].
- Busy outputs: mem_rbusy = state in {RD_REQ, RD_WAIT}; mem_wbusy = state in {WR_REQ, WR_WAIT}.
- ERR lasts one cycle:
  - rbusy is held high if the access was a read, wbusy if it was a write.
  - mem_rdata <= ERR_DATA on reads.
  - Returns to IDLE.
- Timeout counter:
  - Cleared on leaving IDLE; increments each cycle in a REQ/WAIT state.
  - Reaching TIMEOUT forces ERR with the same effects as an unmapped access.
  - A response arriving in the same cycle as the timeout wins; no error is raised.
- Error capture:
  - On entry to ERR, if err_valid=0: set err_valid, latch err_addr (full address) and err_is_write.
  - Later errors do not overwrite the capture.
  - err_clear clears err_valid the next cycle; an error in the same cycle as err_clear sets err_valid and recaptures (set wins).
- Stray or non-selected s_rvalid/s_wready inputs are ignored.
- Reset, including mid-transaction:
  - State returns to IDLE; the timeout counter is cleared.
  - mem_rdata=0, rbusy=wbusy=0, s_ren=s_wen=0.
  - s_addr/s_wdata/s_wstrb=0, err_valid=0, err_addr=0, err_is_write=0.
  - An in-flight access is abandoned; no s_ren/s_wen is issued after reset.

Test Plan:
- Read slave 1 at 0x1000_0004, slave returns rvalid with 0x0000_001F in the same cycle as ren -> s_ren=3'b010 at cycle 1, s_addr=0x4, mem_rdata=0x1F with rbusy=0 at cycle 2.
- Write 0x2000_0000, wdata=0x41, wmask=4'b0001, s_wready delayed 3 cycles -> s_wen=3'b100 for one cycle; wbusy high until the cycle after wready; s_wstrb=4'b0001.
- Read unmapped 0x5000_0000 -> no s_ren; mem_rdata=0xDEADBEEF after one ERR cycle; err_valid=1, err_addr=0x5000_0000, err_is_write=0.
- Read slave 0 that never responds, TIMEOUT=8 -> rbusy high for 9 cycles, then mem_rdata=0xDEADBEEF; a second timeout does not change err_addr; err_clear -> err_valid=0.
- Simultaneous wmask=4'hF and rstrb to 0x0000_0010 -> only s_wen[0] issued; no s_ren.
- rst asserted while in RD_WAIT -> next cycle all outputs at reset values; a late s_rvalid is ignored and mem_rdata stays 0.

Source files
------------

// File: rtl/bus_fabric_n.sv
// N-slave interconnect between the FemtoRV32 memory port and memory-mapped peripherals.
// Base/mask decode, registered request issue, ready/valid completion, timeout and sticky error capture.
//
// state   | meaning
// IDLE    | waiting for a master read or write request
// RD_REQ  | s_ren pulse to the latched slave
// RD_WAIT | waiting for s_rvalid of the latched slave
// WR_REQ  | s_wen pulse to the latched slave
// WR_WAIT | waiting for s_wready of the latched slave
// ERR     | one-cycle error completion (unmapped or timed out)
module bus_fabric_n #(
  parameter int                         N_SLAVES   = 3,
  parameter int                         DATA_W     = 32,
  parameter int                         ADDR_W     = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {3{32'hF000_0000}},
  parameter int                         TIMEOUT    = 255,
  parameter int                         TO_W       = 8,
  parameter logic [DATA_W-1:0]          ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W/8-1:0]          mem_wmask,
  input  logic                         mem_rstrb,
  output logic [DATA_W-1:0]            mem_rdata,
  output logic                         mem_rbusy,
  output logic                         mem_wbusy,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [N_SLAVES-1:0]          s_ren,
  output logic [N_SLAVES-1:0]          s_wen,
  input  logic [N_SLAVES-1:0]          s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_wready,
  input  logic                         err_clear,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  output logic                         err_is_write
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [ADDR_W-1:0] hit_mask;
  logic [IDX_W-1:0]  idx;
  logic              op_write;
  logic [ADDR_W-1:0] addr_full;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              wr_req, rd_req, accept;
  logic              rvalid_sel, wready_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic [N_SLAVES-1:0] idx_onehot;
  logic              rd_done;

  // Reverse scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_mask   = SLAVE_MASK[hit_idx*ADDR_W +: ADDR_W];
  assign wr_req     = |mem_wmask;
  assign rd_req     = mem_rstrb;
  assign accept     = (state == IDLE) && (wr_req || rd_req);
  assign rvalid_sel = s_rvalid[idx];
  assign wready_sel = s_wready[idx];
  assign rdata_sel  = s_rdata[idx*DATA_W +: DATA_W];
  assign idx_onehot = N_SLAVES'(1) << idx;
  assign to_hit     = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    s_ren     = '0;
    s_wen     = '0;
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nx = hit ? WR_REQ : ERR;
        end else if (rd_req) begin
          state_nx = hit ? RD_REQ : ERR;
        end
      end
      RD_REQ: begin
        s_ren     = idx_onehot;
        mem_rbusy = 1'b1;
        if (rvalid_sel) begin
          rd_done  = 1'b1;
          state_nx = IDLE;
        end else if (to_hit) begin
          state_nx = ERR;
        end else begin
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_rbusy = 1'b1;
        if (rvalid_sel) begin
          rd_done  = 1'b1;
          state_nx = IDLE;
        end else if (to_hit) begin
          state_nx = ERR;
        end
      end
      WR_REQ: begin
        s_wen     = idx_onehot;
        mem_wbusy = 1'b1;
        if (wready_sel) begin
          state_nx = IDLE;
        end else if (to_hit) begin
          state_nx = ERR;
        end else begin
          state_nx = WR_WAIT;
        end
      end
      WR_WAIT: begin
        mem_wbusy = 1'b1;
        if (wready_sel) begin
          state_nx = IDLE;
        end else if (to_hit) begin
          state_nx = ERR;
        end
      end
      ERR: begin
        mem_rbusy = ~op_write;
        mem_wbusy = op_write;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      op_write  <= 1'b0;
      addr_full <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
    end else if (accept) begin
      idx       <= hit_idx;
      op_write  <= wr_req;
      addr_full <= mem_addr;
      s_addr    <= mem_addr & ~hit_mask;
      if (wr_req) begin
        s_wdata <= mem_wdata;
        s_wstrb <= mem_wmask;
      end
    end
  end

  // Held at zero in IDLE so every transaction starts its budget from zero.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == ERR) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else if (rd_done) begin
      mem_rdata <= rdata_sel;
    end else if (state == ERR && !op_write) begin
      mem_rdata <= ERR_DATA;
    end
  end

  // A new error beats a simultaneous clear and recaptures.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
    end else if (state == ERR && (!err_valid || err_clear)) begin
      err_valid    <= 1'b1;
      err_addr     <= addr_full;
      err_is_write <= op_write;
    end else if (err_clear) begin
      err_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_fabric_n.sv
// Directed bench for bus_fabric_n: reads, writes, unmapped/timeout errors, error capture and reset.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_bus_fabric_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ren;
  logic [2:0]  s_wen;
  logic [2:0]  s_rvalid;
  logic [95:0] s_rdata;
  logic [2:0]  s_wready;
  logic        err_clear;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_is_write;

  int n_vec  = 0;
  int n_miss = 0;
  int n_busy;

  always #5 clk = ~clk;

  bus_fabric_n #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ren(s_ren), .s_wen(s_wen),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_wready(s_wready),
    .err_clear(err_clear), .err_valid(err_valid), .err_addr(err_addr), .err_is_write(err_is_write)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    s_rvalid = '0; s_wready = '0; err_clear = 1'b0;
    s_rdata = {32'hBBBB_BBBB, 32'h0000_001F, 32'hAAAA_AAAA};
    step(); step();
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_busy", {30'h0, mem_rbusy, mem_wbusy}, 32'h0);
    chk("rst_en", {26'h0, s_ren, s_wen}, 32'h0);
    chk("rst_err", {31'h0, err_valid}, 32'h0);
    rst = 1'b0;
    step();

    // Read slave 1, response in the same cycle as ren.
    mem_addr = 32'h1000_0004; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0; s_rvalid = 3'b010;
    chk("rd1_ren", {29'h0, s_ren}, 32'h2);
    chk("rd1_saddr", s_addr, 32'h4);
    chk("rd1_rbusy_c1", {31'h0, mem_rbusy}, 32'h1);
    step();
    s_rvalid = '0;
    chk("rd1_rdata", mem_rdata, 32'h0000_001F);
    chk("rd1_rbusy_c2", {31'h0, mem_rbusy}, 32'h0);
    chk("rd1_ren_off", {29'h0, s_ren}, 32'h0);

    // Write slave 2, wready three cycles after wen, stray wready on slave 0.
    mem_addr = 32'h2000_0000; mem_wdata = 32'h41; mem_wmask = 4'b0001;
    step();
    mem_wmask = '0;
    chk("wr_wen", {29'h0, s_wen}, 32'h4);
    chk("wr_wstrb", {28'h0, s_wstrb}, 32'h1);
    chk("wr_wdata", s_wdata, 32'h41);
    chk("wr_saddr", s_addr, 32'h0);
    chk("wr_wbusy_c1", {31'h0, mem_wbusy}, 32'h1);
    step();
    s_wready = 3'b001;
    chk("wr_wen_once", {29'h0, s_wen}, 32'h0);
    chk("wr_wbusy_c2", {31'h0, mem_wbusy}, 32'h1);
    step();
    s_wready = '0;
    chk("wr_stray_ign", {31'h0, mem_wbusy}, 32'h1);
    step();
    s_wready = 3'b100;
    chk("wr_wbusy_c4", {31'h0, mem_wbusy}, 32'h1);
    step();
    s_wready = '0;
    chk("wr_wbusy_done", {31'h0, mem_wbusy}, 32'h0);

    // Unmapped read.
    mem_addr = 32'h5000_0000; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    chk("um_no_ren", {29'h0, s_ren}, 32'h0);
    chk("um_rbusy_err", {31'h0, mem_rbusy}, 32'h1);
    step();
    chk("um_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("um_rbusy_done", {31'h0, mem_rbusy}, 32'h0);
    chk("um_err_valid", {31'h0, err_valid}, 32'h1);
    chk("um_err_addr", err_addr, 32'h5000_0000);
    chk("um_err_wr", {31'h0, err_is_write}, 32'h0);

    // Slave 0 never answers: TIMEOUT=8 gives 8 request/wait cycles plus ERR.
    s_rdata[31:0] = 32'h1234_5678;
    mem_addr = 32'h0000_0100; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    n_busy = 0;
    while (mem_rbusy && n_busy < 30) begin
      n_busy++;
      step();
    end
    chk("to_busy_cycles", n_busy, 32'd9);
    chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_err_keep", err_addr, 32'h5000_0000);

    // Unmapped write while clearing: the new error wins and recaptures.
    mem_addr = 32'h7000_0000; mem_wmask = 4'hF; mem_wdata = 32'h9;
    step();
    mem_wmask = '0; err_clear = 1'b1;
    chk("umw_wbusy", {30'h0, mem_rbusy, mem_wbusy}, 32'h1);
    step();
    err_clear = 1'b0;
    chk("umw_err_valid", {31'h0, err_valid}, 32'h1);
    chk("umw_err_addr", err_addr, 32'h7000_0000);
    chk("umw_err_wr", {31'h0, err_is_write}, 32'h1);
    chk("umw_rdata_keep", mem_rdata, 32'hDEAD_BEEF);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_err_valid", {31'h0, err_valid}, 32'h0);

    // Simultaneous write and read: write wins, read dropped.
    mem_addr = 32'h0000_0010; mem_wmask = 4'hF; mem_rstrb = 1'b1; mem_wdata = 32'hCAFE_0001;
    step();
    mem_wmask = '0; mem_rstrb = 1'b0; s_wready = 3'b001;
    chk("sim_wen", {29'h0, s_wen}, 32'h1);
    chk("sim_no_ren", {29'h0, s_ren}, 32'h0);
    chk("sim_busy", {30'h0, mem_rbusy, mem_wbusy}, 32'h1);
    step();
    s_wready = '0;
    chk("sim_done", {30'h0, mem_rbusy, mem_wbusy}, 32'h0);
    step();
    chk("sim_read_dropped", {26'h0, s_ren, s_wen}, 32'h0);

    // Reset during RD_WAIT, then a late rvalid must be ignored.
    mem_addr = 32'h2000_0008; mem_rstrb = 1'b1;
    step();
    mem_rstrb = 1'b0;
    chk("rr_ren", {29'h0, s_ren}, 32'h4);
    step();
    chk("rr_wait_busy", {31'h0, mem_rbusy}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; s_rvalid = 3'b100;
    chk("rr_rbusy", {31'h0, mem_rbusy}, 32'h0);
    chk("rr_rdata", mem_rdata, 32'h0);
    chk("rr_saddr", s_addr, 32'h0);
    chk("rr_swdata", s_wdata, 32'h0);
    chk("rr_err", {err_addr[30:0], err_valid}, 32'h0);
    step();
    s_rvalid = '0;
    chk("rr_late_rdata", mem_rdata, 32'h0);
    chk("rr_late_en", {26'h0, s_ren, s_wen}, 32'h0);
    chk("rr_late_busy", {30'h0, mem_rbusy, mem_wbusy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
